skid_buffer_sync_rst: RTL

//  Two-entry valid/ready register slice (skid buffer) that breaks every

---
 rtl/skid_buffer_sync_rst.sv | 113 +++++++++++
 1 files changed

// File: rtl/skid_buffer_sync_rst.sv
// Two-entry valid/ready register slice (skid buffer).
// Forward data/valid and backward ready all come straight from flops, so
// no combinational path crosses the block in either direction. A main
// register feeds the consumer, and a skid register catches the one beat
// that arrives in the cycle m_ready drops.
module skid_buffer_sync_rst #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] skid;
  logic             s_fire;
  logic             m_fire;
  logic             load_main_s;
  logic             load_main_skid;
  logic             load_skid;
  logic             m_valid_next;
  logic             s_ready_next;

  assign s_fire = s_valid & s_ready;
  assign m_fire = m_valid & m_ready;

  // State register; reset always returns to EMPTY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Occupancy transitions driven by the two handshakes.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (s_fire) state_next = BUSY;
      end
      BUSY: begin
        if (s_fire && !m_fire)      state_next = FULL;
        else if (!s_fire && m_fire) state_next = EMPTY;
      end
      FULL: begin
        if (m_fire) state_next = BUSY;
      end
      default: state_next = EMPTY;
    endcase
  end

  // Register load strobes and the next values of the registered handshakes.
  always_comb begin
    load_main_s    = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    m_valid_next   = (state_next != EMPTY);
    s_ready_next   = (state_next != FULL);
    case (state)
      EMPTY: begin
        load_main_s = s_fire;
      end
      BUSY: begin
        load_main_s = s_fire & m_fire;
        load_skid   = s_fire & ~m_fire;
      end
      FULL: begin
        load_main_skid = m_fire;
      end
      default: begin
        load_main_s = 1'b0;
      end
    endcase
  end

  // Output flops and skid register; s_ready stays low during the reset edge
  // so the first cycle after reset can never accept a beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_ready <= 1'b0;
      m_data  <= RESET_VAL;
      skid    <= RESET_VAL;
    end else begin
      m_valid <= m_valid_next;
      s_ready <= s_ready_next;
      if (load_main_s) begin
        m_data <= s_data;
      end else if (load_main_skid) begin
        m_data <= skid;
      end
      if (load_skid) begin
        skid <= s_data;
      end
    end
  end

endmodule
